// File: rtl/cursor_mover.sv
// Frame-rate cursor position generator: moves the cursor once per vsync falling edge,
// with hold-to-accelerate stepping and clamp or wrap behaviour at the display edges.
module cursor_mover #(
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 10,
    parameter int X_MAX        = 640,
    parameter int Y_MAX        = 480,
    parameter int X_INIT       = 320,
    parameter int Y_INIT       = 240,
    parameter int STEP_MAX     = 8,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       move_en,
    input  logic                       up,
    input  logic                       down,
    input  logic                       left,
    input  logic                       right,
    input  logic                       home,
    input  logic                       wrap_en,
    input  logic                       vsync,
    input  logic [X_WIDTH-1:0]         x_min,
    output logic [X_WIDTH-1:0]         x_pos,
    output logic [Y_WIDTH-1:0]         y_pos,
    output logic [$clog2(STEP_MAX):0]  step,
    output logic                       update
);

    localparam int SW = $clog2(STEP_MAX) + 1;
    localparam int HW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    // Two guard bits: one for the sign of pos - step, one for pos + step overflow.
    localparam int AW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

    localparam logic signed [AW-1:0] X_HI = AW'(X_MAX);
    localparam logic signed [AW-1:0] Y_HI = AW'(Y_MAX);
    localparam logic signed [AW-1:0] Y_LO = '0;
    localparam logic signed [AW-1:0] ONE  = AW'(1);

    typedef enum logic {
        IDLE,
        HELD
    } acc_state_e;

    logic                vsync_q;
    logic                update_q;
    logic [X_WIDTH-1:0]  x_q,     x_d;
    logic [Y_WIDTH-1:0]  y_q,     y_d;
    logic [SW-1:0]       step_q,  step_d;
    logic [HW-1:0]       hold_q,  hold_d;
    acc_state_e          state_q, state_d;

    logic                tick;
    logic                x_act, y_act, any_act;
    logic                x_oor, y_oor;
    logic signed [AW-1:0] x_ext, y_ext, x_lo, step_ext;
    logic signed [AW-1:0] x_nxt, y_nxt;

    function automatic logic signed [AW-1:0] step_axis(
        input logic signed [AW-1:0] pos,
        input logic signed [AW-1:0] stp,
        input logic                 dec,
        input logic signed [AW-1:0] lo,
        input logic signed [AW-1:0] hi,
        input logic                 wrap
    );
        logic signed [AW-1:0] n;
        if (dec) begin
            n = pos - stp;
            if (n < lo) n = wrap ? (n + (hi - lo)) : lo;
        end else begin
            n = pos + stp;
            if (n >= hi) n = wrap ? (n - (hi - lo)) : (hi - ONE);
        end
        return n;
    endfunction

    function automatic logic signed [AW-1:0] recover(
        input logic signed [AW-1:0] pos,
        input logic signed [AW-1:0] lo,
        input logic signed [AW-1:0] hi
    );
        return (pos < lo) ? lo : (hi - ONE);
    endfunction

    assign tick     = vsync_q & ~vsync;
    assign x_act    = left ^ right;
    assign y_act    = up ^ down;
    assign any_act  = x_act | y_act;

    assign x_ext    = $signed(AW'(x_q));
    assign y_ext    = $signed(AW'(y_q));
    assign x_lo     = $signed(AW'(x_min));
    assign step_ext = $signed(AW'(step_q));

    assign x_oor    = (x_ext < x_lo) || (x_ext >= X_HI);
    assign y_oor    = (y_ext < Y_LO) || (y_ext >= Y_HI);

    // An out-of-range axis snaps back into bounds and ignores its buttons this tick.
    always_comb begin
        x_nxt = x_ext;
        if (x_oor) begin
            x_nxt = recover(x_ext, x_lo, X_HI);
        end else if (x_act) begin
            x_nxt = step_axis(x_ext, step_ext, left, x_lo, X_HI, wrap_en);
        end
    end

    always_comb begin
        y_nxt = y_ext;
        if (y_oor) begin
            y_nxt = recover(y_ext, Y_LO, Y_HI);
        end else if (y_act) begin
            y_nxt = step_axis(y_ext, step_ext, up, Y_LO, Y_HI, wrap_en);
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        step_d  = step_q;
        hold_d  = hold_q;
        state_d = state_q;
        if (tick) begin
            if (!move_en || home) begin
                if (move_en) begin
                    x_d = X_WIDTH'(X_INIT);
                    y_d = Y_WIDTH'(Y_INIT);
                end
                step_d  = SW'(1);
                hold_d  = '0;
                state_d = IDLE;
            end else begin
                x_d = X_WIDTH'(x_nxt);
                y_d = Y_WIDTH'(y_nxt);
                if (any_act) begin
                    state_d = HELD;
                    if (hold_q == HW'(ACCEL_FRAMES - 1)) begin
                        hold_d = '0;
                        step_d = (step_q == SW'(STEP_MAX)) ? step_q : (step_q << 1);
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    step_d  = SW'(1);
                    hold_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            update_q <= 1'b0;
            x_q      <= X_WIDTH'(X_INIT);
            y_q      <= Y_WIDTH'(Y_INIT);
            step_q   <= SW'(1);
            hold_q   <= '0;
            state_q  <= IDLE;
        end else begin
            vsync_q  <= vsync;
            update_q <= tick;
            x_q      <= x_d;
            y_q      <= y_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
        end
    end

    assign x_pos  = x_q;
    assign y_pos  = y_q;
    assign step   = step_q;
    assign update = update_q;

endmodule
